// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester handshakes, read return and SRAM macro pins for the
// SRAM port arbiter. The slave side is the arbiter; the master side is the
// surrounding logic (loader, PE array, SRAM macros).
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256
);
  logic              i_load_start;
  logic              i_ld_req;
  logic              i_ld_last;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [DATA_W-1:0] i_ld_data;
  logic              o_ld_gnt;
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_gnt;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_gnt;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_busy;
  logic              o_CEN;
  logic              o_WEN;
  logic [ADDR_W-1:0] o_A;
  logic [DATA_W-1:0] o_D;
  logic [DATA_W-1:0] i_Q;

  modport master (
    output i_load_start, i_ld_req, i_ld_last, i_ld_addr, i_ld_data,
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_Q,
    input  o_ld_gnt, o_wr_gnt, o_rd_gnt, o_rd_data, o_rd_valid, o_busy,
    input  o_CEN, o_WEN, o_A, o_D
  );

  modport slave (
    input  i_load_start, i_ld_req, i_ld_last, i_ld_addr, i_ld_data,
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_Q,
    output o_ld_gnt, o_wr_gnt, o_rd_gnt, o_rd_data, o_rd_valid, o_busy,
    output o_CEN, o_WEN, o_A, o_D
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter for the T loader, PE write-back and PE read-fetch.
// RUN mode arbitrates PE traffic (write first, read forced after STARVE_MAX
// lost cycles); DRAIN waits for in-flight reads to return; LOAD admits only
// the loader until its last word. SRAM pins are registered, reads return
// RD_LAT cycles after the registered CEN with a valid pulse.
module sram_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 256,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  sram_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t            state;
  logic              busy;
  logic              ld_gnt, wr_gnt, rd_gnt, any_gnt;
  logic              starve_hit, pipe_empty;
  logic [CNT_W-1:0]  starve_cnt;

  logic              cen_p0, wen_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic [RD_LAT-1:0] vld_p;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] rd_data_p1;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
  // The output valid register counts as part of the read pipe so a read
  // still being presented keeps the mode change waiting one more cycle.
  assign pipe_empty = ~(|vld_p) & ~rd_vld_p1;
  assign any_gnt    = ld_gnt | wr_gnt | rd_gnt;

  // Grant decode: at most one grant, none in the cycle that requests LOAD.
  always_comb begin
    ld_gnt = 1'b0;
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    case (state)
      RUN: begin
        if (!bus.i_load_start) begin
          if (bus.i_rd_req && (starve_hit || !bus.i_wr_req)) rd_gnt = 1'b1;
          else if (bus.i_wr_req)                             wr_gnt = 1'b1;
        end
      end
      LOAD:    ld_gnt = bus.i_ld_req;
      default: ;
    endcase
  end

  // Mode FSM with registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: if (bus.i_load_start) begin
          state <= DRAIN;
          busy  <= 1'b1;
        end
        DRAIN: if (pipe_empty) state <= LOAD;
        LOAD: if (ld_gnt && bus.i_ld_last) begin
          state <= RUN;
          busy  <= 1'b0;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read starvation counter: only PE arbitration in RUN can starve a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         starve_cnt <= '0;
    else if (rd_gnt)                                    starve_cnt <= '0;
    else if (state == RUN && bus.i_rd_req && !starve_hit) starve_cnt <= starve_cnt + CNT_W'(1);
  end

  // Stage p0: registered SRAM command; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_p0  <= 1'b1;
      wen_p0  <= 1'b1;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else begin
      cen_p0 <= ~any_gnt;
      wen_p0 <= ~(ld_gnt | wr_gnt);
      if (ld_gnt) begin
        addr_p0 <= bus.i_ld_addr;
        data_p0 <= bus.i_ld_data;
      end else if (wr_gnt) begin
        addr_p0 <= bus.i_wr_addr;
        data_p0 <= bus.i_wr_data;
      end else if (rd_gnt) begin
        addr_p0 <= bus.i_rd_addr;
      end
    end
  end

  // Stage p1: read-valid shift register and captured read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p      <= '0;
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p[0] <= rd_gnt;
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
      rd_vld_p1 <= vld_p[RD_LAT-1];
      if (vld_p[RD_LAT-1]) rd_data_p1 <= bus.i_Q;
    end
  end

  assign bus.o_ld_gnt   = ld_gnt;
  assign bus.o_wr_gnt   = wr_gnt;
  assign bus.o_rd_gnt   = rd_gnt;
  assign bus.o_busy     = busy;
  assign bus.o_CEN      = cen_p0;
  assign bus.o_WEN      = wen_p0;
  assign bus.o_A        = addr_p0;
  assign bus.o_D        = data_p0;
  assign bus.o_rd_valid = rd_vld_p1;
  assign bus.o_rd_data  = rd_data_p1;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed stimulus with a read-data scoreboard
// and a behavioural SRAM macro with a two-cycle read latency.
module tb_sram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // SRAM macro: command sampled one edge after it is registered, Q one edge later.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] shd [0:1023];
  logic [DW-1:0] q_r;
  always @(posedge clk) begin
    if (!bus.o_CEN) begin
      if (!bus.o_WEN) mem[bus.o_A] <= bus.o_D;
      else            q_r <= mem[bus.o_A];
    end
  end
  assign bus.i_Q = q_r;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic g_ld, g_wr, g_rd;

  function automatic logic [DW-1:0] init_word(int a);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(a);
    return {8{w}};
  endfunction

  function automatic logic [DW-1:0] wdata(int k);
    logic [31:0] w;
    w = 32'hBEEF_0000 | 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [DW-1:0] ldata(int k);
    logic [31:0] w;
    w = 32'h1D00_0000 | 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus: sample grants before the edge, update the scoreboard.
  task automatic tick();
    @(negedge clk);
    g_ld = bus.o_ld_gnt;
    g_wr = bus.o_wr_gnt;
    g_rd = bus.o_rd_gnt;
    if (rst_n) begin
      if (g_rd) exp_q.push_back(shd[bus.i_rd_addr]);
      if (g_wr) shd[bus.i_wr_addr] = bus.i_wr_data;
      if (g_ld) shd[bus.i_ld_addr] = bus.i_ld_data;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every returned read word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_rd_valid) begin
      rv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got=%0h expected=none", bus.o_rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.o_rd_data !== e) begin
          errors++;
          $display("FAIL rd_data got=%0h expected=%0h", bus.o_rd_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wk, rk, rv_base, rv_mark, n_before;
    logic got_ld;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = init_word(i);
      shd[i] = init_word(i);
    end
    rst_n = 1'b0;
    bus.i_load_start = 1'b0;
    bus.i_ld_req = 1'b0; bus.i_ld_last = 1'b0; bus.i_ld_addr = '0; bus.i_ld_data = '0;
    bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cen", bus.o_CEN, 1);
    chk("rst_wen", bus.o_WEN, 1);
    chk("rst_a", bus.o_A, 0);
    chk("rst_d", bus.o_D, 0);
    chk("rst_rd_data", bus.o_rd_data, 0);
    chk("rst_rd_valid", bus.o_rd_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read latency: single read of address 5
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 10'd5;
    tick();
    bus.i_rd_req = 1'b0;
    chk("t2_gnt", g_rd, 1);
    chk("t2_cen", bus.o_CEN, 0);
    chk("t2_wen", bus.o_WEN, 1);
    chk("t2_a", bus.o_A, 5);
    chk("t2_vld_e1", bus.o_rd_valid, 0);
    @(posedge clk); #1;
    chk("t2_vld_e2", bus.o_rd_valid, 0);
    chk("t2_cen_idle", bus.o_CEN, 1);
    @(posedge clk); #1;
    chk("t2_vld_e3", bus.o_rd_valid, 1);
    chk("t2_data", bus.o_rd_data, init_word(5));
    @(posedge clk); #1;
    chk("t2_pulse", bus.o_rd_valid, 0);

    // Reset while a read is in flight
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 10'd7;
    tick();
    bus.i_rd_req = 1'b0;
    chk("t1_gnt", g_rd, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("t1_cen", bus.o_CEN, 1);
    chk("t1_a", bus.o_A, 0);
    chk("t1_rd_data", bus.o_rd_data, 0);
    chk("t1_rd_valid", bus.o_rd_valid, 0);
    rv_mark = rv_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t1_no_return", 32'(rv_cnt), 32'(rv_mark));

    // Contention: write and read held high, 4:1 pattern
    wk = 0; rk = 0;
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 10'd100; bus.i_wr_data = wdata(0);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 10'd100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_rd_gnt%0d", i), g_rd, (i % 5 == 4));
      chk($sformatf("t3_wr_gnt%0d", i), g_wr, (i % 5 != 4));
      if (g_wr) begin wk++; bus.i_wr_addr = 10'(100 + wk); bus.i_wr_data = wdata(wk); end
      if (g_rd) begin rk++; bus.i_rd_addr = 10'(100 + rk); end
    end
    bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Load: three reads in flight, then LOAD request
    rv_base = rv_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.i_rd_req = 1'b1; bus.i_rd_addr = 10'(20 + i);
      tick();
      chk($sformatf("t4_rd_gnt%0d", i), g_rd, 1);
    end
    bus.i_rd_req = 1'b0;
    bus.i_load_start = 1'b1;
    bus.i_ld_req = 1'b1; bus.i_ld_addr = 10'd0; bus.i_ld_data = ldata(0); bus.i_ld_last = 1'b0;
    tick();
    bus.i_load_start = 1'b0;
    chk("t4_start_nognt", {g_ld, g_wr, g_rd}, 0);
    chk("t4_busy", bus.o_busy, 1);
    // PE traffic held across DRAIN and LOAD
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 10'd300; bus.i_wr_data = wdata(99);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 10'd3;
    got_ld = 1'b0;
    for (int i = 0; i < 20 && !got_ld; i++) begin
      n_before = rv_cnt;
      tick();
      chk($sformatf("t4_drain_pe%0d", i), {g_wr, g_rd}, 0);
      if (g_ld) begin
        got_ld = 1'b1;
        chk("t4_drained", 32'(n_before), 32'(rv_base + 3));
      end
    end
    chk("t4_ld_granted", got_ld, 1);
    for (int a = 1; a < 8; a++) begin
      bus.i_ld_addr = 10'(a); bus.i_ld_data = ldata(a); bus.i_ld_last = (a == 7);
      chk($sformatf("t4_busy_ld%0d", a), bus.o_busy, 1);
      tick();
      chk($sformatf("t4_ld_gnt%0d", a), g_ld, 1);
      chk($sformatf("t5_pe_blocked%0d", a), {g_wr, g_rd}, 0);
    end
    bus.i_ld_req = 1'b0; bus.i_ld_last = 1'b0;
    chk("t4_busy_clr", bus.o_busy, 0);

    // PE traffic resumes in RUN
    tick();
    chk("t5_wr_gnt", g_wr, 1);
    chk("t5_rd_wait", g_rd, 0);
    bus.i_wr_req = 1'b0;
    tick();
    chk("t5_rd_gnt", g_rd, 1);
    bus.i_rd_req = 1'b0;

    // Write then read of the same address
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 10'd3; bus.i_wr_data = {32{8'hA5}};
    tick();
    chk("t6_wr_gnt", g_wr, 1);
    bus.i_wr_req = 1'b0;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 10'd3;
    tick();
    chk("t6_rd_gnt", g_rd, 1);
    bus.i_rd_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_vld", bus.o_rd_valid, 1);
    chk("t6_data", bus.o_rd_data, {32{8'hA5}});

    repeat (6) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
